// File: rtl/io_pkg.sv
// Shared constants, debounce state encoding and the hex-to-7-segment decoder for io_bridge.
package io_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DB_W   = 20;
  localparam int unsigned DIV_W  = 17;

  localparam logic [ADDR_W-1:0] IO_LED    = 8'h00;
  localparam logic [ADDR_W-1:0] IO_SEG    = 8'h08;
  localparam logic [ADDR_W-1:0] IO_STAT   = 8'h0C;
  localparam logic [ADDR_W-1:0] IO_SWLAT  = 8'h10;
  localparam logic [ADDR_W-1:0] IO_SWLIVE = 8'h14;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_COUNT  = 1'b1
  } db_state_e;

  // Active-low segments, bit 6 = g ... bit 0 = a
  function automatic logic [SEG_W-1:0] hex7seg(input logic [3:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/io_bridge_if.sv
// CPU-side I/O bus: address, store data and strobe from the CPU, load data back to it.
interface io_bridge_if;
  import io_pkg::*;

  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_dout;
  logic              io_we;
  logic [DATA_W-1:0] io_din;

  modport master (output io_addr, output io_dout, output io_we, input io_din);
  modport slave  (input io_addr, input io_dout, input io_we, output io_din);
endinterface

// File: rtl/io_debounce.sv
// Button synchroniser and debouncer: the level changes only after the synchronised
// input has disagreed with it for DB_CNT+1 consecutive cycles; o_rise pulses after a 0->1 change.
module io_debounce
  import io_pkg::*;
#(
  parameter logic [DB_W-1:0] DB_CNT = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_lvl,
  output logic o_rise
);

  logic [1:0]      r_sync;
  logic            w_btn;
  db_state_e       r_state, w_state_nxt;
  logic [DB_W-1:0] r_cnt, w_cnt_nxt;
  logic            r_lvl, w_lvl_nxt;
  logic            r_rise, w_rise_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[0], i_btn};
  end

  assign w_btn = r_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DB_STABLE;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lvl   <= w_lvl_nxt;
      r_rise  <= w_rise_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lvl_nxt   = r_lvl;
    w_rise_nxt  = 1'b0;
    case (r_state)
      DB_STABLE: begin
        if (w_btn != r_lvl) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DB_COUNT;
        end
      end
      DB_COUNT: begin
        if (w_btn == r_lvl) begin
          w_state_nxt = DB_STABLE;
        end else if (r_cnt == DB_CNT - 20'd1) begin
          w_lvl_nxt   = w_btn;
          w_rise_nxt  = w_btn;
          w_state_nxt = DB_STABLE;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      default: w_state_nxt = DB_STABLE;
    endcase
  end

  assign o_lvl  = r_lvl;
  assign o_rise = r_rise;

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped I/O unit: LED and 7-segment registers, switch readback and a
// debounced button event that latches the switches until the CPU acknowledges it.
module io_bridge
  import io_pkg::*;
#(
  parameter int unsigned      LED_W    = 16,
  parameter int unsigned      SW_W     = 16,
  parameter logic [DB_W-1:0]  DB_CNT   = 20'd1_000_000,
  parameter logic [DIV_W-1:0] SCAN_DIV = 17'd100_000
) (
  input  logic              clk,
  input  logic              rst,
  io_bridge_if.slave        bus,
  input  logic [SW_W-1:0]   sw,
  input  logic              btn,
  output logic [LED_W-1:0]  led,
  output logic [DIGITS-1:0] an,
  output logic [SEG_W-1:0]  seg
);

  logic [LED_W-1:0]  r_led;
  logic [DATA_W-1:0] r_seg;
  logic [SW_W-1:0]   r_sw_meta, r_sw_sync, r_sw_lat;
  logic              r_evt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [DIGITS-1:0] r_an;
  logic [SEG_W-1:0]  r_seg_o;
  logic [DATA_W-1:0] w_seg_nxt, w_din;
  logic [3:0]        w_nib;
  logic              w_we_led, w_we_seg, w_we_stat, w_wrap;
  logic              w_db_lvl, w_rise, w_evt_set;

  io_debounce #(.DB_CNT(DB_CNT)) u_db (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn),
    .o_lvl  (w_db_lvl),
    .o_rise (w_rise)
  );

  assign w_we_led  = bus.io_we && (bus.io_addr == IO_LED);
  assign w_we_seg  = bus.io_we && (bus.io_addr == IO_SEG);
  assign w_we_stat = bus.io_we && (bus.io_addr == IO_STAT);
  assign w_evt_set = w_rise && w_db_lvl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led     <= '0;
      r_seg     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      if (w_we_led) r_led <= bus.io_dout[LED_W-1:0];
      if (w_we_seg) r_seg <= bus.io_dout;
    end
  end

  // A new press outranks an acknowledge arriving in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_evt    <= 1'b0;
      r_sw_lat <= '0;
    end else if (w_evt_set) begin
      r_evt    <= 1'b1;
      r_sw_lat <= r_sw_sync;
    end else if (w_we_stat) begin
      r_evt    <= 1'b0;
    end
  end

  // Next scan slot and the seg_r value it will see, so an/seg stay registered yet current
  always_comb begin
    w_wrap    = (r_div == SCAN_DIV - 17'd1);
    w_div_nxt = w_wrap ? '0 : r_div + 17'd1;
    w_idx_nxt = w_wrap ? r_idx + 3'd1 : r_idx;
    w_seg_nxt = w_we_seg ? bus.io_dout : r_seg;
    w_nib     = w_seg_nxt[{w_idx_nxt, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      r_idx   <= '0;
      r_an    <= 8'hFE;
      r_seg_o <= 7'b1000000;
    end else begin
      r_div   <= w_div_nxt;
      r_idx   <= w_idx_nxt;
      r_an    <= ~(DIGITS'(1) << w_idx_nxt);
      r_seg_o <= hex7seg(w_nib);
    end
  end

  always_comb begin
    w_din = '0;
    case (bus.io_addr)
      IO_LED:    w_din = DATA_W'(r_led);
      IO_SEG:    w_din = r_seg;
      IO_STAT:   w_din = DATA_W'(r_evt);
      IO_SWLAT:  w_din = DATA_W'(r_sw_lat);
      IO_SWLIVE: w_din = DATA_W'(r_sw_sync);
      default:   w_din = '0;
    endcase
  end

  assign bus.io_din = w_din;
  assign led        = r_led;
  assign an         = r_an;
  assign seg        = r_seg_o;

endmodule
